data_mem_responder: RTL and testbench

//  Responder (slave) side of the memory-stage data interface. It accepts one load or store

---
 rtl/data_mem_responder_pkg.sv | 25 ++
 rtl/data_mem_responder_dmem_array.sv | 32 +++
 rtl/data_mem_responder.sv | 113 +++++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the memory-stage data responder: word width,
// default geometry/latency, FSM state encoding and the request legality rule.
// Ports: none (package).
package data_mem_responder_pkg;

    localparam int WORD         = 64;
    localparam int DMEM_DEPTH   = 128;
    localparam int DMEM_LATENCY = 2;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_WAIT = 2'd1,
        DMR_RESP = 2'd2
    } dmr_state_t;

    // A request is illegal if it is both a load and a store, is not
    // doubleword aligned, or falls at or beyond the end of the array.
    function automatic logic req_illegal(input logic             rd,
                                         input logic             wr,
                                         input logic [WORD-1:0]  addr,
                                         input logic [WORD-1:0]  limit);
        return (rd & wr) | (addr[2:0] != 3'b000) | (addr >= limit);
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Doubleword storage for the data responder: synchronous write, combinational
// read by index, whole array cleared by synchronous reset.
// Ports: clk, reset, wr_en/wr_idx/wr_data (write side), rd_idx/rd_data (read side).
module dmem_array #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data responder: accepts one load/store at a time, services it
// from an internal doubleword array after LATENCY edges, stalls the pipeline via busy.
// Ports: clk, reset, mem_read/mem_write/address/write_data (request), read_data/busy/done/err (response).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] write_data,
    output logic [WORD-1:0] read_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [WORD-1:0] ADDR_LIMIT = WORD'(DEPTH * 8);

    dmr_state_t      state;
    logic [3:0]      cnt;
    logic            rd_q;
    logic            wr_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;

    logic            req;
    logic            illegal;
    logic            commit;
    logic [AW-1:0]   idx;
    logic [WORD-1:0] arr_rdata;

    assign req     = mem_read | mem_write;
    // Legality is judged on the latched request so later input changes cannot affect it.
    assign illegal = req_illegal(rd_q, wr_q, addr_q, ADDR_LIMIT);
    assign idx     = addr_q[AW+2:3];
    assign commit  = (state == DMR_WAIT) && (cnt == 4'd0);

    // The stall is asserted in the same cycle the request is presented so the
    // pipeline holds its inputs through the acceptance edge; it drops in RESP
    // so the pipeline advances on the edge that leaves RESP.
    assign busy = ((state == DMR_IDLE) && req) || (state == DMR_WAIT);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (WORD)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit && wr_q && !illegal),
        .wr_idx  (idx),
        .wr_data (wdata_q),
        .rd_idx  (idx),
        .rd_data (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DMR_IDLE;
            cnt       <= 4'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                DMR_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req) begin
                        rd_q    <= mem_read;
                        wr_q    <= mem_write;
                        addr_q  <= address;
                        wdata_q <= write_data;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= DMR_WAIT;
                    end
                end
                DMR_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Commit edge: store goes to the array via wr_en, load result is registered.
                        state <= DMR_RESP;
                        done  <= 1'b1;
                        err   <= illegal;
                        if (rd_q) begin
                            read_data <= illegal ? '0 : arr_rdata;
                        end
                    end
                end
                DMR_RESP: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= DMR_IDLE;
                end
                default: begin
                    state <= DMR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a LATENCY=2 instance and a
// LATENCY=1 instance, each checked against an array/last-load model.
// Ports: none (top-level bench).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default latency 2; instance 1: latency 1.
    logic        a_rst, a_rd, a_wr, a_busy, a_done, a_err;
    logic [63:0] a_addr, a_wd, a_rdata;
    logic        b_rst, b_rd, b_wr, b_busy, b_done, b_err;
    logic [63:0] b_addr, b_wd, b_rdata;

    data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut_a (
        .clk(clk), .reset(a_rst), .mem_read(a_rd), .mem_write(a_wr),
        .address(a_addr), .write_data(a_wd), .read_data(a_rdata),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    data_mem_responder #(.DEPTH(128), .LATENCY(1)) dut_b (
        .clk(clk), .reset(b_rst), .mem_read(b_rd), .mem_write(b_wr),
        .address(b_addr), .write_data(b_wd), .read_data(b_rdata),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    int          errors = 0;
    int          checks = 0;
    int          lat [2] = '{2, 1};
    logic [63:0] mem_m [2][128];
    logic [63:0] last_load [2];

    logic        r_rd;
    logic [63:0] r_a, r_wd;
    int          r_s, r_k;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_illegal(input logic rd, input logic wr, input logic [63:0] a);
        return (rd && wr) || (a % 8 != 0) || (a >= 64'd1024);
    endfunction

    function automatic logic busy_of(input int s);
        return (s == 0) ? a_busy : b_busy;
    endfunction
    function automatic logic done_of(input int s);
        return (s == 0) ? a_done : b_done;
    endfunction
    function automatic logic err_of(input int s);
        return (s == 0) ? a_err : b_err;
    endfunction
    function automatic logic [63:0] rdata_of(input int s);
        return (s == 0) ? a_rdata : b_rdata;
    endfunction

    task automatic drive(input int s, input logic rd, input logic wr,
                         input logic [63:0] a, input logic [63:0] wd);
        if (s == 0) begin
            a_rd = rd; a_wr = wr; a_addr = a; a_wd = wd;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = a; b_wd = wd;
        end
    endtask

    task automatic clear_model(input int s);
        for (int i = 0; i < 128; i++) mem_m[s][i] = '0;
        last_load[s] = '0;
    endtask

    // Entered just after a falling edge with the responder idle. Presents a
    // request, waits for done, then presents the follow-on request (or none)
    // in the done cycle, as a pipeline that advances when busy drops would.
    task automatic run_req(input int s, input logic rd, input logic wr,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic nrd, input logic nwr,
                           input logic [63:0] na, input logic [63:0] nwd);
        logic        ill;
        int          dc, bc;
        logic        got_err;
        logic [63:0] got_rd;
        drive(s, rd, wr, a, wd);
        #1;
        chk("busy_on_request", busy_of(s), 1'b1);
        @(posedge clk);
        ill = is_illegal(rd, wr, a);
        if (rd) last_load[s] = ill ? 64'd0 : mem_m[s][a / 8];
        if (wr && !ill) mem_m[s][a / 8] = wd;
        dc = -1; bc = 0; got_err = 1'bx; got_rd = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done_of(s)) begin
                dc = c; got_err = err_of(s); got_rd = rdata_of(s);
                break;
            end
            if (busy_of(s)) bc++;
        end
        chk("done_cycle", 64'(dc), 64'(lat[s] + 1));
        if (dc > 0) begin
            chk("busy_cycles", 64'(bc), 64'(lat[s]));
            chk("err", got_err, ill);
            chk("read_data", got_rd, last_load[s]);
            chk("busy_in_resp", busy_of(s), 1'b0);
        end
        drive(s, nrd, nwr, na, nwd);
        @(negedge clk);
        chk("done_pulse_end", done_of(s), 1'b0);
        chk("idle_busy", busy_of(s), nrd | nwr);
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        clear_model(0);
        clear_model(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state of both instances.
        chk("rst_a_read_data", a_rdata, 64'd0);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_done", a_done, 1'b0);
        chk("rst_a_err", a_err, 1'b0);
        chk("rst_b_read_data", b_rdata, 64'd0);
        chk("rst_b_busy", b_busy, 1'b0);
        chk("rst_b_done", b_done, 1'b0);
        chk("rst_b_err", b_err, 1'b0);
        run_req(0, 1, 0, 64'h40, 0, 0, 0, 0, 0);

        // Store then immediately load the same doubleword.
        run_req(0, 0, 1, 64'h18, 64'hDEADBEEF_CAFEF00D, 1, 0, 64'h18, 0);
        run_req(0, 1, 0, 64'h18, 0, 0, 0, 0, 0);
        chk("store_load_value", a_rdata, 64'hDEADBEEF_CAFEF00D);

        // Misaligned load, then confirm the array is untouched.
        run_req(0, 1, 0, 64'h1C, 0, 0, 0, 0, 0);
        run_req(0, 1, 0, 64'h18, 0, 0, 0, 0, 0);

        // Read+write together, out of range, and the last legal doubleword.
        run_req(0, 1, 1, 64'h20, 64'h55, 0, 0, 0, 0);
        run_req(0, 1, 0, 64'h20, 0, 0, 0, 0, 0);
        run_req(0, 1, 0, 64'd1024, 0, 0, 0, 0, 0);
        run_req(0, 0, 1, 64'd1024, 64'h1234, 0, 0, 0, 0);
        run_req(0, 0, 1, 64'h3F8, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
        run_req(0, 1, 0, 64'h3F8, 0, 0, 0, 0, 0);

        // Reset during WAIT of a store: aborted, no done, store dropped.
        drive(0, 0, 1, 64'h08, 64'h77);
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_in_wait", a_busy, 1'b1);
        a_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        clear_model(0);
        #1;
        chk("abort_busy", a_busy, 1'b0);
        chk("abort_read_data", a_rdata, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", a_done, 1'b0);
            @(negedge clk);
        end
        run_req(0, 1, 0, 64'h08, 0, 0, 0, 0, 0);

        // Latency-1 instance: stores, then back-to-back loads held against busy.
        run_req(1, 0, 1, 64'h00, 64'hAAAA_0000_1111_2222, 0, 1, 64'h08, 64'h5555_3333_4444_6666);
        run_req(1, 0, 1, 64'h08, 64'h5555_3333_4444_6666, 1, 0, 64'h00, 0);
        run_req(1, 1, 0, 64'h00, 0, 1, 0, 64'h08, 0);
        run_req(1, 1, 0, 64'h08, 0, 0, 0, 0, 0);

        // Random legal/illegal loads and stores over a small address window.
        for (int i = 0; i < 48; i++) begin
            r_s  = int'($urandom_range(0, 1));
            r_rd = 1'($urandom_range(0, 1));
            r_a  = 64'($urandom_range(0, 15)) * 8;
            r_k  = int'($urandom_range(0, 7));
            if (r_k == 0) r_a = r_a + 64'($urandom_range(1, 7));
            else if (r_k == 1) r_a = 64'd1024 + 64'($urandom_range(0, 2000)) * 8;
            r_wd = {$urandom, $urandom};
            run_req(r_s, r_rd, !r_rd, r_a, r_wd, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
